shift_sequencer: RTL and testbench



---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_sequencer_if.sv | 23 ++
 rtl/shift_step_unit.sv | 32 +++
 rtl/shift_sequencer.sv | 80 ++++++++
 tb/tb_shift_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths, opcodes and FSM encodings for the shift sequencer
package shift_pkg;
    localparam int SHIFT_W = 32;
    localparam int AMT_W   = 5;

    typedef enum logic [2:0] {
        SHR  = 3'b000,
        SHRA = 3'b001,
        SHL  = 3'b010,
        ROR  = 3'b011,
        ROL  = 3'b100
    } shift_op_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= ROL;
    endfunction
endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - start/result handshake between control unit and shift sequencer
interface shift_sequencer_if;
    import shift_pkg::*;

    logic               in_start;
    logic [2:0]         in_op;
    logic [SHIFT_W-1:0] in_value;
    logic [AMT_W-1:0]   in_amount;
    logic               out_busy;
    logic               out_done;
    logic               out_err;
    logic [SHIFT_W-1:0] out_result;

    modport master (
        output in_start, in_op, in_value, in_amount,
        input  out_busy, out_done, out_err, out_result
    );

    modport slave (
        input  in_start, in_op, in_value, in_amount,
        output out_busy, out_done, out_err, out_result
    );
endinterface

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - combinational single step: shift/rotate acc by n bits, 0 <= n <= STEP
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic [SHIFT_W-1:0] i_acc,
    input  logic [2:0]         i_op,
    input  logic [AMT_W-1:0]   i_n,
    output logic [SHIFT_W-1:0] o_acc
);
    logic [SHIFT_W-1:0] w_next;

    // One constant-distance mux leg per legal n keeps the shifter only STEP bits wide.
    always_comb begin
        w_next = i_acc;
        for (int k = 1; k <= STEP; k++) begin
            if (i_n == AMT_W'(k)) begin
                case (i_op)
                    SHR:     w_next = i_acc >> k;
                    SHRA:    w_next = $unsigned($signed(i_acc) >>> k);
                    SHL:     w_next = i_acc << k;
                    ROR:     w_next = (i_acc >> k) | (i_acc << (SHIFT_W - k));
                    ROL:     w_next = (i_acc << k) | (i_acc >> (SHIFT_W - k));
                    default: w_next = i_acc;
                endcase
            end
        end
    end

    assign o_acc = w_next;
endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift/rotate sequencer, at most STEP bits per clock
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic               in_clk,
    input  logic               in_rst,
    shift_sequencer_if.slave   bus
);
    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic [SHIFT_W-1:0] r_acc;
    logic [AMT_W-1:0]   r_rem;
    logic               r_err;
    logic [SHIFT_W-1:0] r_result;

    logic [AMT_W-1:0]   w_n;
    logic [SHIFT_W-1:0] w_next_acc;
    logic               w_accept;
    logic               w_legal;

    assign w_n      = (r_rem > AMT_W'(STEP)) ? AMT_W'(STEP) : r_rem;
    assign w_accept = bus.in_start && (r_state != ST_SHIFT);
    assign w_legal  = op_legal(bus.in_op);

    shift_step_unit #(.STEP(STEP)) u_step (
        .i_acc (r_acc),
        .i_op  (r_op),
        .i_n   (w_n),
        .o_acc (w_next_acc)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= bus.in_op;
            r_acc <= bus.in_value;
            // Illegal ops skip SHIFT entirely and report the operand unchanged.
            if (!w_legal || bus.in_amount == '0) begin
                r_rem    <= '0;
                r_state  <= ST_DONE;
                r_result <= bus.in_value;
                r_err    <= !w_legal;
            end else begin
                r_rem   <= bus.in_amount;
                r_state <= ST_SHIFT;
                r_err   <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_acc <= w_next_acc;
                    r_rem <= r_rem - w_n;
                    if (r_rem == w_n) begin
                        r_state  <= ST_DONE;
                        r_result <= w_next_acc;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b0;
                end
                ST_IDLE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_busy   = (r_state == ST_SHIFT);
    assign bus.out_done   = (r_state == ST_DONE);
    assign bus.out_err    = (r_state == ST_DONE) && r_err;
    assign bus.out_result = r_result;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed bench with a latency/result model for shift_sequencer
module tb_shift_sequencer;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    shift_sequencer_if bus();

    shift_sequencer #(.STEP(STEP)) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] v, input int a);
        logic [63:0] dbl;
        dbl = {v, v};
        case (op)
            3'b000:  return v >> a;
            3'b001:  return $unsigned($signed(v) >>> a);
            3'b010:  return v << a;
            3'b011:  return 32'(dbl >> a);
            3'b100:  return 32'((dbl << a) >> 32);
            default: return v;
        endcase
    endfunction

    // Model: an accepted op keeps busy high for ceil(amount/STEP) cycles, then done for one.
    int          m_left   = 0;
    logic        m_done   = 1'b0;
    logic        m_err    = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;
    logic        m_perr   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_err = 0; m_result = '0; m_pend = '0; m_perr = 0;
        end else if (bus.in_start && m_left == 0) begin
            int k;
            logic legal;
            legal  = (bus.in_op <= 3'b100);
            k      = legal ? (int'(bus.in_amount) + STEP - 1) / STEP : 0;
            m_pend = ref_shift(bus.in_op, bus.in_value, int'(bus.in_amount));
            m_perr = !legal;
            if (k == 0) begin
                m_done = 1; m_err = m_perr; m_result = m_pend; m_left = 0;
            end else begin
                m_done = 0; m_err = 0; m_left = k;
            end
        end else if (m_left != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1; m_err = m_perr; m_result = m_pend;
            end
        end else begin
            m_done = 0; m_err = 0;
        end
    end

    always @(negedge clk) begin
        tests++;
        if (bus.out_busy !== (m_left != 0) || bus.out_done !== m_done ||
            bus.out_err !== m_err || bus.out_result !== m_result) begin
            fails++;
            $display("FAIL cycle@%0t: got busy=%0b done=%0b err=%0b result=%h, want busy=%0b done=%0b err=%0b result=%h",
                     $time, bus.out_busy, bus.out_done, bus.out_err, bus.out_result,
                     (m_left != 0), m_done, m_err, m_result);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] v, input logic [4:0] a, input bit now);
        if (!now) @(negedge clk);
        bus.in_start  = 1'b1;
        bus.in_op     = op;
        bus.in_value  = v;
        bus.in_amount = a;
        @(negedge clk);
        bus.in_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] exp_res, input int exp_busy,
                             input logic exp_err, input bit poke);
        int  busy_cnt;
        bit  seen;
        busy_cnt = 0;
        seen     = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_done) begin
                seen = 1;
                break;
            end
            if (bus.out_busy) busy_cnt++;
            if (poke && busy_cnt == 1 && bus.out_busy) begin
                bus.in_start  = 1'b1;
                bus.in_op     = 3'b111;
                bus.in_value  = 32'hFFFF_FFFF;
                bus.in_amount = 5'd1;
            end else begin
                bus.in_start = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_start = 1'b0;
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_result"}, bus.out_result, exp_res);
        check({name, "_model"}, m_result, exp_res);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({name, "_err"}, 32'(bus.out_err), 32'(exp_err));
    endtask

    initial begin
        bit saw_done;
        bus.in_start  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_value  = '0;
        bus.in_amount = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_busy",   32'(bus.out_busy), 32'd0);
        check("reset_done",   32'(bus.out_done), 32'd0);
        check("reset_err",    32'(bus.out_err),  32'd0);
        check("reset_result", bus.out_result,    32'h0);
        @(negedge clk);
        rst = 1'b0;

        start_op(3'b000, 32'h8000_0000, 5'd31, 0);
        wait_done("shr31", 32'h0000_0001, 8, 1'b0, 0);
        start_op(3'b001, 32'h8000_0000, 5'd4, 0);
        wait_done("shra4", 32'hF800_0000, 1, 1'b0, 0);
        start_op(3'b100, 32'h8000_0001, 5'd5, 0);
        wait_done("rol5", 32'h0000_0030, 2, 1'b0, 0);
        start_op(3'b011, 32'h0000_0001, 5'd1, 0);
        wait_done("ror1", 32'h8000_0000, 1, 1'b0, 0);
        start_op(3'b010, 32'h1234_5678, 5'd0, 0);
        wait_done("shl0", 32'h1234_5678, 0, 1'b0, 0);
        start_op(3'b111, 32'hDEAD_BEEF, 5'd7, 0);
        wait_done("illegal", 32'hDEAD_BEEF, 0, 1'b1, 0);
        start_op(3'b010, 32'h0000_0001, 5'd12, 0);
        wait_done("shl12_poke", 32'h0000_1000, 3, 1'b0, 1);
        start_op(3'b011, 32'h0000_000F, 5'd4, 1);
        wait_done("b2b_ror4", 32'hF000_0000, 1, 1'b0, 0);
        start_op(3'b010, 32'h0000_0003, 5'd31, 1);
        wait_done("b2b_shl31", 32'h8000_0000, 8, 1'b0, 0);

        start_op(3'b000, 32'hFFFF_FFFF, 5'd20, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",   32'(bus.out_busy), 32'd0);
        check("midrst_done",   32'(bus.out_done), 32'd0);
        check("midrst_result", bus.out_result,    32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_done || bus.out_busy) saw_done = 1;
        end
        check("midrst_quiet", 32'(saw_done), 32'd0);
        start_op(3'b000, 32'h8000_0000, 5'd8, 0);
        wait_done("after_rst", 32'h0080_0000, 2, 1'b0, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
